// File: rtl/sevenseg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: slot length,
// hex-to-segment patterns and the digit index width helper.
package sevenseg_scan_pkg;

  localparam int SLOT_TICKS = 16;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-high segment pattern; a blanked digit lights nothing.
module seg_decode
  import sevenseg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  assign pattern = blank ? 7'h00 : SEG_PATTERNS[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit hex display driver with prescaler, PWM brightness,
// leading-zero blanking, decimal points and a frame-aligned load handshake.
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 10,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic [3:0]              brightness,
  input  logic                    blank_lz,
  output logic                    ld_ack,
  output logic                    frame_start,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int              IW        = idx_width(NUM_DIGITS);
  localparam int              SW        = $clog2(SLOT_TICKS);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0]   LAST_SLOT = SW'(SLOT_TICKS - 1);
  localparam logic            INV       = (ACTIVE_LOW != 0);

  logic [DIV_BITS-1:0]     prescale;
  logic [SW-1:0]           slot_tick;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow_val, disp_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                    pending;

  logic                    tick, slot_end, wrap;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS-1:0]   en_onehot;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [6:0]              pattern;

  assign tick        = &prescale;
  assign slot_end    = tick && (slot_tick == LAST_SLOT);
  assign wrap        = slot_end && (idx == LAST_IDX);
  assign frame_start = wrap;
  assign ld_ack      = wrap && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale  <= '0;
      slot_tick <= '0;
      idx       <= '0;
    end else begin
      prescale <= prescale + 1'b1;
      if (tick)
        slot_tick <= slot_tick + 1'b1;
      if (slot_end)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // Shadow and display registers are cleared on reset so a reset mid-frame
  // leaves nothing stale to show or transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make a same-cycle load and transfer
      // safe: the display takes the shadow's old contents, not the new write.
      if (wrap && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
      end
      if (load)
        pending <= 1'b1;
      else if (wrap)
        pending <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above   = zero_above && (disp_val[4*k +: 4] == 4'h0);
      blank_vec[k] = blank_lz && (k != 0) && zero_above;
    end
  end

  always_comb begin
    en_onehot = '0;
    if (slot_tick < brightness)
      en_onehot[idx] = 1'b1;
  end

  assign cur_nibble = disp_val[4*idx +: 4];
  assign cur_blank  = blank_vec[idx];

  seg_decode u_decode (
    .nibble  (cur_nibble),
    .blank   (cur_blank),
    .pattern (pattern)
  );

  // Polarity is applied here so the decoder stays active-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= {7{INV}};
      seg_dp <= INV;
      dig_en <= {NUM_DIGITS{INV}};
    end else begin
      seg    <= pattern ^ {7{INV}};
      seg_dp <= (disp_dp[idx] && !cur_blank) ^ INV;
      dig_en <= en_onehot ^ {NUM_DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench: directed scenarios plus random loads, compared cycle by
// cycle against a frame-arithmetic model; a second instance covers ACTIVE_LOW.
module tb_sevenseg_scan;

  localparam int ND    = 4;
  localparam int DB    = 2;
  localparam int SLOT  = 64;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  brightness;
  logic        blank_lz;

  logic        ld_ack, frame_start, seg_dp;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        ld_ack_al, frame_start_al, seg_dp_al;
  logic [6:0]  seg_al;
  logic [3:0]  dig_en_al;

  int tests = 0;
  int fails = 0;

  int          t;
  logic [15:0] m_sh_val, m_disp_val;
  logic [3:0]  m_sh_dp, m_disp_dp;
  bit          m_pending;

  logic [6:0] seg_table [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  sevenseg_scan #(.NUM_DIGITS(ND), .DIV_BITS(DB), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .brightness(brightness), .blank_lz(blank_lz), .ld_ack(ld_ack),
    .frame_start(frame_start), .seg(seg), .seg_dp(seg_dp), .dig_en(dig_en)
  );

  sevenseg_scan #(.NUM_DIGITS(ND), .DIV_BITS(DB), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .brightness(brightness), .blank_lz(blank_lz), .ld_ack(ld_ack_al),
    .frame_start(frame_start_al), .seg(seg_al), .seg_dp(seg_dp_al), .dig_en(dig_en_al)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s at t=%0d: observed %h expected %h", tag, t, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic bit boundary(input int tt);
    return (tt % FRAME) == FRAME - 1;
  endfunction

  task automatic model_reset();
    t          = 0;
    m_sh_val   = '0;
    m_sh_dp    = '0;
    m_disp_val = '0;
    m_disp_dp  = '0;
    m_pending  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_seg",         seg,            16'h0000);
    check("rst_seg_dp",      seg_dp,         16'h0000);
    check("rst_dig_en",      dig_en,         16'h0000);
    check("rst_ld_ack",      ld_ack,         16'h0000);
    check("rst_frame_start", frame_start,    16'h0000);
    check("rst_seg_al",      seg_al,         16'h007F);
    check("rst_seg_dp_al",   seg_dp_al,      16'h0001);
    check("rst_dig_en_al",   dig_en_al,      16'h000F);
    check("rst_ld_ack_al",   ld_ack_al,      16'h0000);
  endtask

  // One clock: check pulses for the current cycle, predict the registered
  // outputs from the current state, advance the model, then compare.
  task automatic step();
    int         d, s;
    bit         bnd, blank;
    logic [3:0] nib;
    logic [6:0] e_seg, e_seg_n;
    logic       e_dp, e_dp_n;
    logic [3:0] e_en, e_en_n;

    bnd = boundary(t);
    check("frame_start",    frame_start,    16'(bnd));
    check("ld_ack",         ld_ack,         16'(bnd && m_pending));
    check("frame_start_al", frame_start_al, 16'(bnd));
    check("ld_ack_al",      ld_ack_al,      16'(bnd && m_pending));

    d       = (t / SLOT) % ND;
    s       = (t / (SLOT / 16)) % 16;
    nib     = 4'(m_disp_val >> (4 * d));
    blank   = blank_lz && (d > 0) && ((m_disp_val >> (4 * d)) == 16'h0);
    e_seg   = blank ? 7'h00 : seg_table[nib];
    e_dp    = !blank && m_disp_dp[d];
    e_en    = (s < int'(brightness)) ? 4'(1 << d) : 4'h0;
    e_seg_n = ~e_seg;
    e_dp_n  = ~e_dp;
    e_en_n  = ~e_en;

    if (bnd && m_pending) begin
      m_disp_val = m_sh_val;
      m_disp_dp  = m_sh_dp;
      m_pending  = 1'b0;
    end
    if (load) begin
      m_sh_val  = value;
      m_sh_dp   = dp;
      m_pending = 1'b1;
    end
    t++;

    @(posedge clk);
    #1;
    check("seg",       seg,       16'(e_seg));
    check("seg_dp",    seg_dp,    16'(e_dp));
    check("dig_en",    dig_en,    16'(e_en));
    check("seg_al",    seg_al,    16'(e_seg_n));
    check("seg_dp_al", seg_dp_al, 16'(e_dp_n));
    check("dig_en_al", dig_en_al, 16'(e_en_n));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives.
  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    value      = '0;
    dp         = '0;
    load       = 1'b0;
    brightness = 4'd15;
    blank_lz   = 1'b0;
    #12 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    run(100);
    reset_now();

    // A pending load lost to reset must never reach the display.
    do_load(16'h5555, 4'hF);
    run(50);
    reset_now();
    run(300);

    brightness = 4'd15;
    do_load(16'h12A0, 4'b0000);
    run(2 * FRAME);

    brightness = 4'd4;
    run(FRAME);
    brightness = 4'd0;
    run(FRAME);
    brightness = 4'd15;

    blank_lz = 1'b1;
    do_load(16'h0040, 4'b0110);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0011);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // New load landing exactly on the transfer cycle of an older one.
    do_load(16'h1111, 4'b0001);
    while (!boundary(t)) step();
    do_load(16'hBEEF, 4'b1000);
    run(2 * FRAME);

    for (int r = 0; r < 25; r++) begin
      brightness = 4'($urandom_range(0, 15));
      blank_lz   = 1'($urandom_range(0, 1));
      n          = int'($urandom_range(1, 300));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 63) == 0)
          do_load(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom));
        else
          step();
      end
    end
    run(FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
